// File: rtl/sand_pkg.sv
// Shared definitions for the sand-grid datapath.
//   MAT_W          : material code width used by every frame-RAM client
//   COLUMNS_DEF    : default grid width in cells
//   ROWS_DEF       : default grid height in cells
//   material_t     : material codes stored per cell
//   drawer_state_t : states of the brush drawer FSM
package sand_pkg;

    localparam int MAT_W       = 3;
    localparam int COLUMNS_DEF = 640;
    localparam int ROWS_DEF    = 480;

    typedef enum logic [MAT_W-1:0] {
        EMPTY = 3'd0,
        SAND  = 3'd1,
        WALL  = 3'd2,
        WATER = 3'd3
    } material_t;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } drawer_state_t;

endpackage

// File: rtl/mouse_brush_drawer_if.sv
// Write channel from the brush drawer toward the frame-RAM write arbiter.
//   wr_address_o : linear cell address y*COLUMNS+x
//   wr_data_o    : material written to the cell
//   wr_en_o      : write valid
//   wr_ready_i   : arbiter accepts the current write this cycle
// Signal names keep the drawer-side direction suffixes of the codebase.
interface mouse_brush_drawer_if #(
    parameter int ADDR_W = 19,
    parameter int MAT_W  = 3
) ();

    logic [ADDR_W-1:0] wr_address_o;
    logic [MAT_W-1:0]  wr_data_o;
    logic              wr_en_o;
    logic              wr_ready_i;

    modport master (
        output wr_address_o,
        output wr_data_o,
        output wr_en_o,
        input  wr_ready_i
    );

    modport slave (
        input  wr_address_o,
        input  wr_data_o,
        input  wr_en_o,
        output wr_ready_i
    );

endinterface

// File: rtl/mouse_brush_drawer_clip.sv
// Brush footprint clipping for the drawer.
//   cur_x, cur_y : cursor cell (bottom-right corner of the brush)
//   size         : brush size n, footprint is (n+1)x(n+1)
//   x0           : leftmost column, max(x-n,0)
//   in_range     : cursor lies inside the grid
//   start_addr   : linear address of the top-left footprint cell
// Purely combinational; the top registers the results on entry to DRAW.
module brush_clip #(
    parameter int COLUMNS = 640,
    parameter int ROWS    = 480,
    parameter int BRUSH_W = 3,
    localparam int XW     = $clog2(COLUMNS),
    localparam int YW     = $clog2(ROWS),
    localparam int AW     = $clog2(COLUMNS*ROWS)
) (
    input  logic [XW-1:0]      cur_x,
    input  logic [YW-1:0]      cur_y,
    input  logic [BRUSH_W-1:0] size,
    output logic [XW-1:0]      x0,
    output logic               in_range,
    output logic [AW-1:0]      start_addr
);

    logic [XW:0]   x_diff;
    logic [YW:0]   y_diff;
    logic [YW-1:0] y0;

    // One bit wider than the operands: the MSB is the borrow, meaning the
    // brush would extend past the grid edge and is clipped to zero.
    assign x_diff = {1'b0, cur_x} - (XW+1)'(size);
    assign y_diff = {1'b0, cur_y} - (YW+1)'(size);

    assign x0 = x_diff[XW] ? '0 : x_diff[XW-1:0];
    assign y0 = y_diff[YW] ? '0 : y_diff[YW-1:0];

    assign in_range = (32'(cur_x) < COLUMNS) && (32'(cur_y) < ROWS);

    assign start_addr = AW'(y0) * AW'(COLUMNS) + AW'(x0);

endmodule

// File: rtl/mouse_brush_drawer.sv
// Stamps a square brush of selectable size and material into the frame RAM
// at the mouse cursor, one clipped cell per cycle over a valid/ready channel.
//   clk_i, reset_i      : clock, asynchronous active-high reset
//   draw_en_i           : stamp request (mouse button held)
//   mouse_x/y_position_i: cursor cell, bottom-right corner of the brush
//   brush_size_i        : brush size n, footprint (n+1)x(n+1)
//   material_i          : material written into every brush cell
//   wr                  : write channel toward the RAM arbiter
//   busy_o              : stroke in progress
module mouse_brush_drawer
    import sand_pkg::*;
#(
    parameter int COLUMNS = sand_pkg::COLUMNS_DEF,
    parameter int ROWS    = sand_pkg::ROWS_DEF,
    parameter int BRUSH_W = 3,
    parameter int MAT_W   = sand_pkg::MAT_W,
    localparam int XW     = $clog2(COLUMNS),
    localparam int YW     = $clog2(ROWS),
    localparam int AW     = $clog2(COLUMNS*ROWS)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 draw_en_i,
    input  logic [XW-1:0]        mouse_x_position_i,
    input  logic [YW-1:0]        mouse_y_position_i,
    input  logic [BRUSH_W-1:0]   brush_size_i,
    input  logic [MAT_W-1:0]     material_i,
    mouse_brush_drawer_if.master wr,
    output logic                 busy_o
);

    drawer_state_t state_q, state_d;

    logic [XW-1:0]      clip_x0;
    logic               clip_in_range;
    logic [AW-1:0]      clip_start;

    logic [XW-1:0]      x_cur_q, x0_q, x1_q;
    logic [YW-1:0]      y_cur_q, y1_q;
    logic [AW-1:0]      addr_q;
    logic [MAT_W-1:0]   mat_q;

    logic [XW-1:0]      hist_x_q;
    logic [YW-1:0]      hist_y_q;
    logic [BRUSH_W-1:0] hist_n_q;
    logic [MAT_W-1:0]   hist_mat_q;
    logic               hist_vld_q;

    logic repeat_hit, start, beat, last_col, last_cell;

    brush_clip #(
        .COLUMNS (COLUMNS),
        .ROWS    (ROWS),
        .BRUSH_W (BRUSH_W)
    ) u_clip (
        .cur_x      (mouse_x_position_i),
        .cur_y      (mouse_y_position_i),
        .size       (brush_size_i),
        .x0         (clip_x0),
        .in_range   (clip_in_range),
        .start_addr (clip_start)
    );

    assign repeat_hit = hist_vld_q
                     && (hist_x_q   == mouse_x_position_i)
                     && (hist_y_q   == mouse_y_position_i)
                     && (hist_n_q   == brush_size_i)
                     && (hist_mat_q == material_i);

    assign start     = (state_q == IDLE) && draw_en_i && clip_in_range && !repeat_hit;
    assign beat      = (state_q == DRAW) && wr.wr_ready_i;
    assign last_col  = (x_cur_q == x1_q);
    assign last_cell = last_col && (y_cur_q == y1_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DRAW;
            DRAW:    if (beat && last_cell) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            hist_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start)
                hist_vld_q <= 1'b1;
            else if ((state_q == IDLE) && !draw_en_i)
                hist_vld_q <= 1'b0;
        end
    end

    // Datapath registers carry no reset: every output is gated by state_q and
    // the stamp history is qualified by hist_vld_q.
    always_ff @(posedge clk_i) begin
        if (start) begin
            x_cur_q    <= clip_x0;
            x0_q       <= clip_x0;
            x1_q       <= mouse_x_position_i;
            y_cur_q    <= (clip_start >= AW'(COLUMNS) * AW'(mouse_y_position_i))
                          ? mouse_y_position_i
                          : YW'(clip_start / AW'(COLUMNS));
            y1_q       <= mouse_y_position_i;
            addr_q     <= clip_start;
            mat_q      <= material_i;
            hist_x_q   <= mouse_x_position_i;
            hist_y_q   <= mouse_y_position_i;
            hist_n_q   <= brush_size_i;
            hist_mat_q <= material_i;
        end else if (beat && !last_cell) begin
            if (last_col) begin
                // Wrap to the footprint's left edge on the next row.
                x_cur_q <= x0_q;
                y_cur_q <= y_cur_q + 1'b1;
                addr_q  <= addr_q + AW'(COLUMNS) - AW'(x1_q - x0_q);
            end else begin
                x_cur_q <= x_cur_q + 1'b1;
                addr_q  <= addr_q + 1'b1;
            end
        end
    end

    assign wr.wr_en_o      = (state_q == DRAW);
    assign wr.wr_address_o = (state_q == DRAW) ? addr_q : '0;
    assign wr.wr_data_o    = (state_q == DRAW) ? mat_q  : '0;
    assign busy_o          = (state_q == DRAW);

endmodule

// File: tb/tb_mouse_brush_drawer.sv
module tb_mouse_brush_drawer;

    localparam int COLUMNS = 640;
    localparam int ROWS    = 480;
    localparam int AW      = $clog2(COLUMNS*ROWS);

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       draw_en_i;
    logic [9:0] mouse_x_position_i;
    logic [8:0] mouse_y_position_i;
    logic [2:0] brush_size_i;
    logic [2:0] material_i;
    logic       busy_o;

    int checks   = 0;
    int failures = 0;

    int q_addr[$];
    int q_data[$];

    mouse_brush_drawer_if #(.ADDR_W(AW), .MAT_W(3)) wr_bus ();

    mouse_brush_drawer #(
        .COLUMNS (COLUMNS),
        .ROWS    (ROWS),
        .BRUSH_W (3),
        .MAT_W   (3)
    ) dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .draw_en_i          (draw_en_i),
        .mouse_x_position_i (mouse_x_position_i),
        .mouse_y_position_i (mouse_y_position_i),
        .brush_size_i       (brush_size_i),
        .material_i         (material_i),
        .wr                 (wr_bus.master),
        .busy_o             (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Accepted beats, sampled mid-cycle ahead of the completing edge.
    always @(negedge clk_i) begin
        if (wr_bus.wr_en_o && wr_bus.wr_ready_i) begin
            q_addr.push_back(int'(wr_bus.wr_address_o));
            q_data.push_back(int'(wr_bus.wr_data_o));
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_cursor(input int x, input int y, input int n, input int m);
        mouse_x_position_i = 10'(x);
        mouse_y_position_i = 9'(y);
        brush_size_i       = 3'(n);
        material_i         = 3'(m);
    endtask

    // Raise draw_en, wait for a full stroke (bounded), then drop draw_en.
    task automatic run_stroke(input string tag, input int budget);
        bit seen = 0;
        bit done = 0;
        draw_en_i = 1'b1;
        for (int c = 0; c < budget && !done; c++) begin
            tick();
            if (busy_o) seen = 1;
            else if (seen) done = 1;
        end
        if (!done) check({tag, "_timeout"}, int'(busy_o), 0);
        draw_en_i = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int base;
        int busy_cycles;
        int exp_addr[$];

        reset_i            = 1'b1;
        draw_en_i          = 1'b0;
        wr_bus.wr_ready_i  = 1'b1;
        set_cursor(0, 0, 0, 0);
        tick();
        tick();
        check("rst_wr_en", int'(wr_bus.wr_en_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_addr", int'(wr_bus.wr_address_o), 0);
        check("rst_data", int'(wr_bus.wr_data_o), 0);
        reset_i = 1'b0;
        tick();

        // Test 1: single cell, latency and busy width.
        base = q_addr.size();
        set_cursor(10, 5, 0, 1);
        draw_en_i = 1'b1;
        tick();
        check("t1_lat_en", int'(wr_bus.wr_en_o), 1);
        check("t1_lat_busy", int'(busy_o), 1);
        check("t1_lat_addr", int'(wr_bus.wr_address_o), 3210);
        busy_cycles = 0;
        for (int c = 0; c < 10; c++) begin
            if (busy_o) busy_cycles++;
            tick();
        end
        draw_en_i = 1'b0;
        tick();
        check("t1_busy_cycles", busy_cycles, 1);
        check("t1_count", q_addr.size() - base, 1);
        if (q_addr.size() > base) begin
            check("t1_addr", q_addr[base], 3210);
            check("t1_data", q_data[base], 1);
        end

        // Test 2: legacy 2x2.
        base = q_addr.size();
        set_cursor(100, 50, 1, 3);
        run_stroke("t2", 20);
        check("t2_count", q_addr.size() - base, 4);
        exp_addr = '{31459, 31460, 32099, 32100};
        for (int i = 0; i < 4; i++)
            if (base + i < q_addr.size()) begin
                check($sformatf("t2_addr%0d", i), q_addr[base+i], exp_addr[i]);
                check($sformatf("t2_data%0d", i), q_data[base+i], 3);
            end
        check("t2_idle_en", int'(wr_bus.wr_en_o), 0);

        // Test 3: clipping at top-left, then the bottom-right corner.
        base = q_addr.size();
        set_cursor(1, 0, 3, 2);
        run_stroke("t3a", 20);
        check("t3a_count", q_addr.size() - base, 2);
        if (q_addr.size() >= base + 2) begin
            check("t3a_addr0", q_addr[base], 0);
            check("t3a_addr1", q_addr[base+1], 1);
        end
        base = q_addr.size();
        set_cursor(639, 479, 2, 1);
        run_stroke("t3b", 30);
        check("t3b_count", q_addr.size() - base, 9);
        if (q_addr.size() >= base + 9) begin
            check("t3b_first", q_addr[base], 305917);
            check("t3b_row1", q_addr[base+3], 306557);
            check("t3b_last", q_addr[base+8], 307199);
        end

        // Test 4: back-pressure on beat 2.
        base = q_addr.size();
        set_cursor(100, 50, 1, 2);
        draw_en_i = 1'b1;
        tick();
        check("t4_beat1", int'(wr_bus.wr_address_o), 31459);
        tick();
        wr_bus.wr_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("t4_hold_addr%0d", c), int'(wr_bus.wr_address_o), 31460);
            check($sformatf("t4_hold_en%0d", c), int'(wr_bus.wr_en_o), 1);
            check($sformatf("t4_hold_data%0d", c), int'(wr_bus.wr_data_o), 2);
            tick();
        end
        wr_bus.wr_ready_i = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        draw_en_i = 1'b0;
        tick();
        tick();
        check("t4_count", q_addr.size() - base, 4);
        exp_addr = '{31459, 31460, 32099, 32100};
        for (int i = 0; i < 4; i++)
            if (base + i < q_addr.size())
                check($sformatf("t4_addr%0d", i), q_addr[base+i], exp_addr[i]);

        // Test 5: repeat suppression.
        base = q_addr.size();
        set_cursor(100, 50, 1, 1);
        draw_en_i = 1'b1;
        for (int c = 0; c < 100; c++) tick();
        check("t5_hold_count", q_addr.size() - base, 4);
        base = q_addr.size();
        mouse_x_position_i = 10'd101;
        for (int c = 0; c < 20; c++) tick();
        check("t5_move_count", q_addr.size() - base, 4);
        if (q_addr.size() > base) check("t5_move_first", q_addr[base], 31460);
        base = q_addr.size();
        draw_en_i = 1'b0;
        tick();
        tick();
        run_stroke("t5_rearm", 20);
        check("t5_rearm_count", q_addr.size() - base, 4);
        if (q_addr.size() > base) check("t5_rearm_first", q_addr[base], 31460);

        // Test 6a: out-of-range cursor.
        base = q_addr.size();
        set_cursor(640, 10, 1, 1);
        draw_en_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (busy_o) check("t6a_busy", int'(busy_o), 0);
        end
        draw_en_i = 1'b0;
        tick();
        check("t6a_count", q_addr.size() - base, 0);

        // Test 6b: reset during beat 3, then restart from top-left.
        set_cursor(50, 20, 2, 3);
        draw_en_i = 1'b1;
        tick();
        tick();
        tick();
        check("t6b_beat3", int'(wr_bus.wr_address_o), 11570);
        reset_i = 1'b1;
        #1;
        check("t6b_rst_en", int'(wr_bus.wr_en_o), 0);
        check("t6b_rst_busy", int'(busy_o), 0);
        draw_en_i = 1'b0;
        tick();
        reset_i = 1'b0;
        tick();
        base = q_addr.size();
        draw_en_i = 1'b1;
        tick();
        check("t6b_restart_addr", int'(wr_bus.wr_address_o), 11568);
        for (int c = 0; c < 20; c++) tick();
        draw_en_i = 1'b0;
        tick();
        check("t6b_restart_count", q_addr.size() - base, 9);
        if (q_addr.size() >= base + 9)
            check("t6b_restart_last", q_addr[base+8], 12850);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
